// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared constants and helpers for the pattern sequence counter
package pattern_pkg;

  // Default pattern: "101", MSB is the earliest received bit
  localparam int unsigned PAT_W_DEF = 3;
  localparam logic [2:0]  PAT_101   = 3'b101;

  // Match-counting modes, sampled on each accepted bit
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // All-ones value of a w-bit counter, used as the saturation ceiling
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// rtl/pattern_window.sv - serial shift window and fill counter with next-state outputs
module pattern_window #(
  parameter int unsigned PAT_W  = 3,
  parameter int unsigned FILL_W = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              drop_fill,
  output logic [PAT_W-1:0]  next_window,
  output logic [FILL_W-1:0] next_fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window;
  logic [FILL_W-1:0] fill;

  // Next state for an accepted bit; clr discards the bit, idle cycles hold
  always_comb begin
    next_window = window;
    next_fill   = fill;
    if (in_valid && !clr) begin
      next_window = {window[PAT_W-2:0], in_bit};
      if (fill != FILL_FULL) next_fill = fill + 1'b1;
    end
  end

  // Window/fill register; a counted non-overlap match restarts the fill
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      window <= '0;
      fill   <= '0;
    end else begin
      window <= next_window;
      fill   <= drop_fill ? '0 : next_fill;
    end
  end

endmodule

// File: rtl/pattern_seq_counter.sv
// rtl/pattern_seq_counter.sv - streaming pattern matcher with saturating count (option: PSC_POS_TRACK_EN)
module pattern_seq_counter
  import pattern_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  output logic             match,
  output logic [CNT_W-1:0] count,
`ifdef PSC_POS_TRACK_EN
  output logic [15:0]      last_pos,
`endif
  output logic             ovf
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(sat_max(CNT_W));

  logic [PAT_W-1:0]  next_window;
  logic [FILL_W-1:0] next_fill;
  logic              accept;
  logic              hit;
  logic              drop_fill;

  pattern_window #(
    .PAT_W  (PAT_W),
    .FILL_W (FILL_W)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .drop_fill   (drop_fill),
    .next_window (next_window),
    .next_fill   (next_fill)
  );

  // A hit needs a freshly accepted bit completing a full window equal to the pattern
  always_comb begin
    accept    = in_valid && !clr;
    hit       = accept && (next_window == PATTERN) && (next_fill == FILL_FULL);
    drop_fill = hit && (overlap == MODE_NONOVL);
  end

  // Match pulse, saturating count and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      match <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      match <= hit;
      if (hit) begin
        if (count < CNT_MAX) count <= count + 1'b1;
        else                 ovf   <= 1'b1;
      end
    end
  end

`ifdef PSC_POS_TRACK_EN
  logic [15:0] bit_idx;

  // Index of each accepted bit; the completing bit's index is latched on a hit
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      bit_idx  <= '0;
      last_pos <= '0;
    end else if (accept) begin
      bit_idx <= bit_idx + 16'd1;
      if (hit) last_pos <= bit_idx;
    end
  end
`endif

endmodule
